// File: rtl/ds1302_xfer_if.sv
// ds1302_xfer_if: request/response bus between the RTC controller and the
// DS1302 transfer engine.
//   start  controller -> engine  one-cycle transfer request
//   cmd    controller -> engine  DS1302 command byte (bit0=1 read, 0 write)
//   wdata  controller -> engine  byte written during a write transfer
//   busy   engine -> controller  transfer in progress
//   done   engine -> controller  one-cycle completion pulse
//   rdata  engine -> controller  last byte read from the device
interface ds1302_xfer_if;
  logic       start;
  logic [7:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (
    output start, cmd, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  start, cmd, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/ds1302_xfer.sv
// ds1302_xfer: byte-serial 3-wire transaction engine for the DS1302 RTC.
// One request runs CE setup, an 8-bit command, an 8-bit data byte (written
// or read, LSB first) and CE recovery. SCLK timing is derived from the
// divider output `tick`, which is edge-detected in the clk domain:
// a tick fall raises SCLK, a tick rise lowers it and advances the bit.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   tick       divider output, treated as a level
//   bus        request/response interface (slave side)
//   ds_ce      DS1302 CE
//   ds_sclk    DS1302 SCLK
//   ds_io_out  IO drive value
//   ds_io_oe   IO output enable (1 = engine drives IO)
//   ds_io_in   IO pin value, already synchronised
module ds1302_xfer #(
  parameter int CE_SETUP_TICKS   = 1,
  parameter int CE_RECOVER_TICKS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  ds1302_xfer_if.slave    bus,
  output logic            ds_ce,
  output logic            ds_sclk,
  output logic            ds_io_out,
  output logic            ds_io_oe,
  input  logic            ds_io_in
);

  typedef enum logic [2:0] {IDLE, SETUP, CMD, DATA, RECOVER} state_t;

  localparam logic [15:0] SETUP_LAST   = 16'(CE_SETUP_TICKS - 1);
  localparam logic [15:0] RECOVER_LAST = 16'(CE_RECOVER_TICKS - 1);

  state_t      state;
  logic        tick_q;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic        rd;
  logic [7:0]  cmd_r;
  logic [7:0]  wdata_r;
  logic [7:0]  shift_r;

  logic rise;
  logic fall;
  logic accept;

  assign rise   = tick & ~tick_q;
  assign fall   = ~tick & tick_q;
  // A start coinciding with the done pulse is dropped so the controller
  // sees a clean idle cycle between transfers.
  assign accept = (state == IDLE) & bus.start & ~bus.done;

  // Control state: FSM, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_q    <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      rd        <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.rdata <= 8'h00;
      ds_ce     <= 1'b0;
      ds_sclk   <= 1'b0;
      ds_io_out <= 1'b0;
      ds_io_oe  <= 1'b0;
    end else begin
      tick_q   <= tick;
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            rd        <= bus.cmd[0];
            bus.busy  <= 1'b1;
            ds_ce     <= 1'b1;
            ds_sclk   <= 1'b0;
            ds_io_oe  <= 1'b1;
            ds_io_out <= bus.cmd[0];
            cnt       <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          // IO already carries cmd[0]; only CE setup time is waited out.
          if (rise) begin
            if (cnt == SETUP_LAST) begin
              idx   <= '0;
              state <= CMD;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        CMD: begin
          if (fall) begin
            ds_sclk <= 1'b1;
          end else if (rise) begin
            ds_sclk <= 1'b0;
            if (idx != 3'd7) begin
              idx       <= idx + 3'd1;
              ds_io_out <= cmd_r[idx + 3'd1];
            end else begin
              idx   <= '0;
              state <= DATA;
              if (rd) ds_io_oe  <= 1'b0;
              else    ds_io_out <= wdata_r[0];
            end
          end
        end
        DATA: begin
          if (fall) begin
            ds_sclk <= 1'b1;
          end else if (rise) begin
            ds_sclk <= 1'b0;
            if (idx != 3'd7) begin
              idx <= idx + 3'd1;
              if (!rd) ds_io_out <= wdata_r[idx + 3'd1];
            end else begin
              ds_ce     <= 1'b0;
              ds_io_oe  <= 1'b0;
              ds_io_out <= 1'b0;
              cnt       <= '0;
              state     <= RECOVER;
            end
          end
        end
        RECOVER: begin
          if (rise) begin
            if (cnt == RECOVER_LAST) begin
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              if (rd) bus.rdata <= shift_r;
              state <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath latches: request capture and read shift register.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_r   <= bus.cmd;
      wdata_r <= bus.wdata;
    end
    // Device data is stable by the tick fall that raises SCLK.
    if (state == DATA && fall && rd) shift_r[idx] <= ds_io_in;
  end

endmodule

// File: tb/tb_ds1302_xfer.sv
module tb_ds1302_xfer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic tick = 1'b0;
  logic io_in = 1'b0;
  logic tick_run = 1'b0;
  logic sel = 1'b0;

  logic ce0, sclk0, io0, oe0;
  logic ce1, sclk1, io1, oe1;

  ds1302_xfer_if bus0 ();
  ds1302_xfer_if bus1 ();

  ds1302_xfer dut0 (
    .clk(clk), .rst(rst), .tick(tick), .bus(bus0),
    .ds_ce(ce0), .ds_sclk(sclk0), .ds_io_out(io0), .ds_io_oe(oe0),
    .ds_io_in(io_in)
  );

  ds1302_xfer #(.CE_SETUP_TICKS(3), .CE_RECOVER_TICKS(4)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .bus(bus1),
    .ds_ce(ce1), .ds_sclk(sclk1), .ds_io_out(io1), .ds_io_oe(oe1),
    .ds_io_in(io_in)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor / tick generator / device model state
  logic m_sclk, m_ce, m_io, m_oe, m_busy, m_done;
  logic [7:0] m_rdata;
  logic p_sclk = 0, p_ce = 0, p_io = 0, p_busy = 0;
  int pulse_cnt = 0, fall_cnt = 0, rise_cnt = 0;
  int rise_first = -1, rise_ce_fall = -1, rise_done = -1;
  int done_total = 0, io_glitch = 0, tc = 0;
  logic [15:0] cap_io = '0, cap_oe = '0;
  logic oe_fall8 = 1'b1;
  logic [7:0] rdata_done = '0;
  logic dev_rd = 1'b0;
  logic [7:0] dev_byte = '0;

  // Everything here runs on the falling clk edge, away from the DUT edge:
  // sample DUT outputs first, then advance tick and the device IO.
  initial begin : bench_loop
    forever begin
      @(negedge clk);
      m_sclk  = sel ? sclk1 : sclk0;
      m_ce    = sel ? ce1 : ce0;
      m_io    = sel ? io1 : io0;
      m_oe    = sel ? oe1 : oe0;
      m_busy  = sel ? bus1.busy : bus0.busy;
      m_done  = sel ? bus1.done : bus0.done;
      m_rdata = sel ? bus1.rdata : bus0.rdata;
      if (m_busy && !p_busy) begin
        pulse_cnt = 0; fall_cnt = 0; rise_cnt = 0;
        rise_first = -1; rise_ce_fall = -1; rise_done = -1;
        cap_io = '0; cap_oe = '0; oe_fall8 = 1'b1;
      end
      if (m_sclk && !p_sclk) begin
        if (pulse_cnt < 16) begin
          cap_io[pulse_cnt] = m_io;
          cap_oe[pulse_cnt] = m_oe;
        end
        if (pulse_cnt == 0) rise_first = rise_cnt;
        pulse_cnt++;
      end
      if (!m_sclk && p_sclk) begin
        fall_cnt++;
        if (fall_cnt == 8) oe_fall8 = m_oe;
        if (dev_rd && fall_cnt >= 8 && fall_cnt < 16) io_in = dev_byte[fall_cnt - 8];
        else io_in = 1'b0;
      end
      if (m_sclk && p_sclk && (m_io != p_io)) io_glitch++;
      if (!m_ce && p_ce && m_busy) rise_ce_fall = rise_cnt;
      if (m_done) begin
        done_total++;
        rise_done = rise_cnt;
        rdata_done = m_rdata;
      end
      p_sclk = m_sclk; p_ce = m_ce; p_io = m_io; p_busy = m_busy;
      if (tick_run) begin
        if (tc == 3) begin
          tc = 0;
          tick = ~tick;
          if (tick) rise_cnt++;
        end else begin
          tc++;
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] c, input logic [7:0] w);
    @(posedge clk); #2;
    if (sel) begin bus1.cmd = c; bus1.wdata = w; bus1.start = 1'b1; end
    else     begin bus0.cmd = c; bus0.wdata = w; bus0.start = 1'b1; end
    @(posedge clk); #2;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  // Returns at posedge+2 of the done cycle.
  task automatic wait_done(input int limit);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < limit) begin
      @(posedge clk); #2;
      n++;
      if (sel ? bus1.done : bus0.done) seen = 1'b1;
    end
    chk("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_pulses(input int num, input int limit);
    int n = 0;
    while (pulse_cnt < num && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    chk("pulse_wait_timeout", 32'(pulse_cnt >= num), 32'd1);
  endtask

  logic [4:0] snap;
  int dt0;

  initial begin
    rst = 1'b1;
    bus0.start = 1'b0; bus0.cmd = '0; bus0.wdata = '0;
    bus1.start = 1'b0; bus1.cmd = '0; bus1.wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus0.done), 32'd0);
    chk("rst_rdata", 32'(bus0.rdata), 32'h00);
    chk("rst_ce", 32'(ce0), 32'd0);
    chk("rst_sclk", 32'(sclk0), 32'd0);
    chk("rst_io_out", 32'(io0), 32'd0);
    chk("rst_io_oe", 32'(oe0), 32'd0);
    rst = 1'b0;
    tick_run = 1'b1;
    repeat (5) @(posedge clk);

    // Write 0x80 / 0x59
    do_start(8'h80, 8'h59);
    wait_done(1000);
    // start in the done cycle must be dropped
    bus0.cmd = 8'h81; bus0.start = 1'b1;
    @(posedge clk); #2;
    bus0.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("done_cycle_start_ignored", 32'(bus0.busy), 32'd0);
    chk("wr_io_bits", 32'(cap_io), 32'h5980);
    chk("wr_oe", 32'(cap_oe), 32'hFFFF);
    chk("wr_pulses", 32'(pulse_cnt), 32'd16);
    chk("wr_first_sclk_rise", 32'(rise_first), 32'd1);
    chk("wr_ce_fall_rise", 32'(rise_ce_fall), 32'd17);
    chk("wr_done_rise", 32'(rise_done), 32'd19);
    chk("wr_rdata", 32'(rdata_done), 32'h00);
    chk("wr_done_count", 32'(done_total), 32'd1);
    chk("wr_io_stable", 32'(io_glitch), 32'd0);

    // Read 0x81, device returns 0x23
    dev_rd = 1'b1; dev_byte = 8'h23;
    do_start(8'h81, 8'h00);
    wait_done(1000);
    repeat (2) @(posedge clk);
    #2;
    dev_rd = 1'b0;
    chk("rd_rdata_done", 32'(rdata_done), 32'h23);
    chk("rd_rdata_hold", 32'(bus0.rdata), 32'h23);
    chk("rd_cmd_bits", 32'(cap_io[7:0]), 32'h81);
    chk("rd_oe", 32'(cap_oe), 32'h00FF);
    chk("rd_oe_at_fall8", 32'(oe_fall8), 32'd0);
    chk("rd_pulses", 32'(pulse_cnt), 32'd16);
    chk("rd_done_rise", 32'(rise_done), 32'd19);

    // start while busy
    dt0 = done_total;
    do_start(8'h80, 8'h59);
    wait_pulses(5, 1000);
    do_start(8'h82, 8'hAA);
    wait_done(1000);
    repeat (300) @(posedge clk);
    #2;
    chk("busy_start_io_bits", 32'(cap_io), 32'h5980);
    chk("busy_start_one_done", 32'(done_total - dt0), 32'd1);
    chk("busy_start_idle", 32'(bus0.busy), 32'd0);
    chk("busy_start_rdata", 32'(bus0.rdata), 32'h23);

    // Reset during DATA bit 3
    do_start(8'h80, 8'h59);
    wait_pulses(12, 1000);
    rst = 1'b1;
    #1;
    chk("midrst_ce", 32'(ce0), 32'd0);
    chk("midrst_sclk", 32'(sclk0), 32'd0);
    chk("midrst_oe", 32'(oe0), 32'd0);
    chk("midrst_busy", 32'(bus0.busy), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    do_start(8'h80, 8'h3C);
    wait_done(1000);
    repeat (2) @(posedge clk);
    #2;
    chk("postrst_io_bits", 32'(cap_io), 32'h3C80);
    chk("postrst_pulses", 32'(pulse_cnt), 32'd16);
    chk("postrst_done_rise", 32'(rise_done), 32'd19);

    // Tick stall mid-CMD
    do_start(8'h80, 8'h59);
    wait_pulses(3, 1000);
    tick_run = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    snap = {ce0, sclk0, io0, oe0, bus0.busy};
    repeat (200) @(posedge clk);
    #2;
    chk("stall_frozen", 32'({ce0, sclk0, io0, oe0, bus0.busy}), 32'(snap));
    chk("stall_busy", 32'(bus0.busy), 32'd1);
    tick_run = 1'b1;
    wait_done(2000);
    repeat (2) @(posedge clk);
    #2;
    chk("stall_io_bits", 32'(cap_io), 32'h5980);
    chk("stall_pulses", 32'(pulse_cnt), 32'd16);
    chk("stall_done_rise", 32'(rise_done), 32'd19);

    // CE_SETUP_TICKS=3, CE_RECOVER_TICKS=4 instance
    sel = 1'b1;
    repeat (2) @(posedge clk);
    do_start(8'h80, 8'h59);
    wait_done(2000);
    repeat (2) @(posedge clk);
    #2;
    chk("p34_first_sclk_rise", 32'(rise_first), 32'd3);
    chk("p34_ce_fall_rise", 32'(rise_ce_fall), 32'd19);
    chk("p34_done_rise", 32'(rise_done), 32'd23);
    chk("p34_io_bits", 32'(cap_io), 32'h5980);
    chk("p34_pulses", 32'(pulse_cnt), 32'd16);
    chk("p34_busy", 32'(bus1.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
